// File: rtl/vx_vpu_operands_pkg.sv
// Shared definitions for the vector operand collector.
//   - opd_state_e  : collector FSM states
//   - NUM_SRC_OPDS : source operands per instruction (vs1/vs2/vs3)
//   - UUID_WIDTH, INST_OP_BITS : instruction metadata widths
//   - up_clog2()   : clog2 that never returns 0 (for 1-entry index fields)
package vx_vpu_operands_pkg;

    localparam int NUM_SRC_OPDS = 3;
    localparam int UUID_WIDTH   = 44;
    localparam int INST_OP_BITS = 4;

    typedef enum logic [1:0] {
        OPD_IDLE,
        OPD_FETCH,
        OPD_DRAIN,
        OPD_OUT
    } opd_state_e;

    function automatic int up_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/vx_vpu_operands_ram.sv
// Dual-port register storage: one write port with per-lane write enables,
// one read port.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   write_i, wren_i         : write strobe and per-lane enables
//   waddr_i, wdata_i        : write address / data
//   raddr_i, rdata_o        : read address / data (combinational when
//                             OUT_REG=0, registered otherwise)
// Contents are only cleared by reset when RESET_RAM is set (debug builds).
module vx_vpu_operands_ram #(
    parameter int DATAW     = 128,
    parameter int SIZE      = 128,
    parameter int WRENW     = 16,
    parameter int OUT_REG   = 0,
    parameter bit RESET_RAM = 1'b0,
    localparam int ADDRW    = $clog2(SIZE),
    localparam int WSELW    = DATAW / WRENW
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             write_i,
    input  logic [WRENW-1:0] wren_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic [ADDRW-1:0] raddr_i,
    output logic [DATAW-1:0] rdata_o
);

    logic [DATAW-1:0] mem_q [SIZE];

    always_ff @(posedge clk_i) begin
        if (RESET_RAM && reset_i) begin
            for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
        end else if (write_i) begin
            for (int b = 0; b < WRENW; b++) begin
                if (wren_i[b]) mem_q[waddr_i][b*WSELW +: WSELW] <= wdata_i[b*WSELW +: WSELW];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATAW-1:0] rdata_q;
            always_ff @(posedge clk_i) rdata_q <= mem_q[raddr_i];
            assign rdata_o = rdata_q;
        end else begin : g_out_comb
            assign rdata_o = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/vx_vpu_operands.sv
// Vector operand collector for one issue slice.
// Accepts an instruction, reads up to three source vector registers from a
// per-slice register file (one read per cycle, ascending vs1..vs3), then
// presents the captured operands with the instruction metadata until the
// consumer accepts. Writebacks land in the register file every cycle.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   in_*               : instruction request (valid/ready, wis, uuid, op, vd,
//                        vs1..vs3 register ids, per-source fetch enables)
//   wb_*               : byte-enabled vector writeback
//   out_*              : collected operands + metadata (valid/ready);
//                        out_vs_data_o[0] is vs1
module vx_vpu_operands
    import vx_vpu_operands_pkg::*;
#(
    parameter int  NUM_VREGS       = 32,
    parameter int  VLEN            = 128,
    parameter int  PER_ISSUE_WARPS = 4,
    parameter bit  GPR_RESET       = 1'b0,
    localparam int VR_BITS         = $clog2(NUM_VREGS),
    localparam int WIS_W           = up_clog2(PER_ISSUE_WARPS),
    localparam int BE_W            = VLEN / 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [WIS_W-1:0]                       in_wis_i,
    input  logic [UUID_WIDTH-1:0]                  in_uuid_i,
    input  logic [INST_OP_BITS-1:0]                in_op_i,
    input  logic [VR_BITS-1:0]                     in_vd_i,
    input  logic [NUM_SRC_OPDS-1:0][VR_BITS-1:0]   in_vs_i,
    input  logic [NUM_SRC_OPDS-1:0]                in_use_i,
    input  logic                                   wb_valid_i,
    input  logic [WIS_W-1:0]                       wb_wis_i,
    input  logic [VR_BITS-1:0]                     wb_vd_i,
    input  logic [BE_W-1:0]                        wb_be_i,
    input  logic [VLEN-1:0]                        wb_data_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [WIS_W-1:0]                       out_wis_o,
    output logic [UUID_WIDTH-1:0]                  out_uuid_o,
    output logic [INST_OP_BITS-1:0]                out_op_o,
    output logic [VR_BITS-1:0]                     out_vd_o,
    output logic [NUM_SRC_OPDS-1:0][VLEN-1:0]      out_vs_data_o
);

    localparam int ADDR_W   = VR_BITS + WIS_W;
    localparam int RAM_SIZE = NUM_VREGS * PER_ISSUE_WARPS;
    localparam int SLOT_W   = $clog2(NUM_SRC_OPDS);

    opd_state_e                           state_q, state_d;
    logic [WIS_W-1:0]                     wis_q;
    logic [UUID_WIDTH-1:0]                uuid_q;
    logic [INST_OP_BITS-1:0]              op_q;
    logic [VR_BITS-1:0]                   vd_q;
    logic [NUM_SRC_OPDS-1:0][VR_BITS-1:0] vs_q;
    logic [NUM_SRC_OPDS-1:0]              pend_q, pend_d;
    logic [NUM_SRC_OPDS-1:0][VLEN-1:0]    opd_q;

    logic                                 fire_in;
    logic                                 rd_issue;
    logic [SLOT_W-1:0]                    rd_slot, rd_slot_q;
    logic                                 rd_vld_q;
    logic [VLEN-1:0]                      rd_data_q;
    logic [VLEN-1:0]                      ram_rdata, fwd_data;
    logic [ADDR_W-1:0]                    raddr, waddr;
    logic                                 wb_hit;

    assign in_ready_o  = (state_q == OPD_IDLE) && !reset_i;
    assign out_valid_o = (state_q == OPD_OUT);
    assign fire_in     = in_valid_i && in_ready_o;

    // Lowest pending source goes next, so reads issue vs1 -> vs2 -> vs3.
    always_comb begin
        rd_slot = '0;
        for (int i = NUM_SRC_OPDS - 1; i >= 0; i--) begin
            if (pend_q[i]) rd_slot = SLOT_W'(i);
        end
    end

    assign raddr = {vs_q[rd_slot], wis_q};
    assign waddr = {wb_vd_i, wb_wis_i};

    // The RAM read returns pre-write contents, so a same-cycle writeback to
    // the address being read is merged in here byte by byte.
    assign wb_hit = wb_valid_i && rd_issue && (waddr == raddr);

    always_comb begin
        fwd_data = ram_rdata;
        for (int b = 0; b < BE_W; b++) begin
            if (wb_hit && wb_be_i[b]) fwd_data[b*8 +: 8] = wb_data_i[b*8 +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        rd_issue = 1'b0;
        case (state_q)
            OPD_IDLE: begin
                if (fire_in) state_d = (in_use_i != '0) ? OPD_FETCH : OPD_OUT;
            end
            OPD_FETCH: begin
                rd_issue        = |pend_q;
                pend_d[rd_slot] = 1'b0;
                if (pend_d == '0) state_d = OPD_DRAIN;
            end
            // Last read's data is still in flight; give it one cycle to land.
            OPD_DRAIN: state_d = OPD_OUT;
            OPD_OUT: begin
                if (out_ready_i) state_d = OPD_IDLE;
            end
            default: state_d = OPD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= OPD_IDLE;
            wis_q     <= '0;
            uuid_q    <= '0;
            op_q      <= '0;
            vd_q      <= '0;
            vs_q      <= '0;
            pend_q    <= '0;
            opd_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_slot_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= rd_issue;
            rd_slot_q <= rd_slot;
            rd_data_q <= fwd_data;
            if (fire_in) begin
                wis_q  <= in_wis_i;
                uuid_q <= in_uuid_i;
                op_q   <= in_op_i;
                vd_q   <= in_vd_i;
                vs_q   <= in_vs_i;
                pend_q <= in_use_i;
                opd_q  <= '0;
            end else begin
                pend_q <= pend_d;
            end
            // Operand slots are written only by their own read, so later
            // writebacks to the same register never disturb captured data.
            if (rd_vld_q) opd_q[rd_slot_q] <= rd_data_q;
        end
    end

    vx_vpu_operands_ram #(
        .DATAW     (VLEN),
        .SIZE      (RAM_SIZE),
        .WRENW     (BE_W),
        .OUT_REG   (0),
        .RESET_RAM (GPR_RESET)
    ) u_gpr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .write_i (wb_valid_i),
        .wren_i  (wb_be_i),
        .waddr_i (waddr),
        .wdata_i (wb_data_i),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign out_wis_o     = wis_q;
    assign out_uuid_o    = uuid_q;
    assign out_op_o      = op_q;
    assign out_vd_o      = vd_q;
    assign out_vs_data_o = opd_q;

endmodule

// File: tb/tb_vx_vpu_operands.sv
module tb_vx_vpu_operands;

    localparam int VL  = 128;
    localparam int VRB = 5;
    localparam int WW  = 2;
    localparam int UW  = 44;
    localparam int OPW = 4;
    localparam int BEW = VL / 8;

    typedef struct {
        logic [WW-1:0]       wis;
        logic [UW-1:0]       uuid;
        logic [OPW-1:0]      op;
        logic [VRB-1:0]      vd;
        logic [2:0][VL-1:0]  data;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [WW-1:0]       in_wis;
    logic [UW-1:0]       in_uuid;
    logic [OPW-1:0]      in_op;
    logic [VRB-1:0]      in_vd;
    logic [2:0][VRB-1:0] in_vs;
    logic [2:0]          in_use;
    logic                wb_valid;
    logic [WW-1:0]       wb_wis;
    logic [VRB-1:0]      wb_vd;
    logic [BEW-1:0]      wb_be;
    logic [VL-1:0]       wb_data;
    logic                out_valid;
    logic                out_ready;
    logic [WW-1:0]       out_wis;
    logic [UW-1:0]       out_uuid;
    logic [OPW-1:0]      out_op;
    logic [VRB-1:0]      out_vd;
    logic [2:0][VL-1:0]  out_vs_data;

    int   vectors = 0;
    int   miscmp  = 0;
    exp_t sb[$];

    vx_vpu_operands #(
        .NUM_VREGS       (32),
        .VLEN            (VL),
        .PER_ISSUE_WARPS (4),
        .GPR_RESET       (1'b1)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_wis_i      (in_wis),
        .in_uuid_i     (in_uuid),
        .in_op_i       (in_op),
        .in_vd_i       (in_vd),
        .in_vs_i       (in_vs),
        .in_use_i      (in_use),
        .wb_valid_i    (wb_valid),
        .wb_wis_i      (wb_wis),
        .wb_vd_i       (wb_vd),
        .wb_be_i       (wb_be),
        .wb_data_i     (wb_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_wis_o     (out_wis),
        .out_uuid_o    (out_uuid),
        .out_op_o      (out_op),
        .out_vd_o      (out_vd),
        .out_vs_data_o (out_vs_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VL-1:0] merge(input logic [VL-1:0] old, input logic [BEW-1:0] be,
                                            input logic [VL-1:0] d);
        logic [VL-1:0] r;
        r = old;
        for (int b = 0; b < BEW; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic wb(input logic [WW-1:0] wis, input logic [VRB-1:0] vd,
                      input logic [BEW-1:0] be, input logic [VL-1:0] d);
        wb_valid = 1'b1; wb_wis = wis; wb_vd = vd; wb_be = be; wb_data = d;
        tick();
        wb_valid = 1'b0; wb_be = '0;
    endtask

    task automatic send(input logic [WW-1:0] wis, input logic [UW-1:0] uuid, input logic [OPW-1:0] op,
                        input logic [VRB-1:0] vd, input logic [VRB-1:0] v1, input logic [VRB-1:0] v2,
                        input logic [VRB-1:0] v3, input logic [2:0] use_m,
                        input logic [VL-1:0] d1, input logic [VL-1:0] d2, input logic [VL-1:0] d3,
                        input bit push);
        exp_t e;
        chk("in_ready_idle", 384'(in_ready), 384'(1'b1));
        in_valid = 1'b1; in_wis = wis; in_uuid = uuid; in_op = op; in_vd = vd;
        in_vs[0] = v1; in_vs[1] = v2; in_vs[2] = v3; in_use = use_m;
        tick();
        in_valid = 1'b0;
        e.wis = wis; e.uuid = uuid; e.op = op; e.vd = vd;
        e.data[0] = d1; e.data[1] = d2; e.data[2] = d3;
        if (push) sb.push_back(e);
    endtask

    // Called at the negedge of cycle T+k0; expects out_valid first at T+lat.
    task automatic wait_valid(input int k0, input int lat);
        int k;
        k = k0;
        while (!out_valid && k < 40) begin
            chk("in_ready_busy", 384'(in_ready), 384'(1'b0));
            tick();
            k++;
        end
        chk("latency", 384'(k), 384'(lat));
    endtask

    task automatic check_out();
        if (sb.size() == 0) begin
            vectors++; miscmp++;
            $error("FAIL scoreboard: observed output, expected empty queue");
        end else begin
            chk("out_valid", 384'(out_valid), 384'(1'b1));
            chk("out_wis",   384'(out_wis),   384'(sb[0].wis));
            chk("out_uuid",  384'(out_uuid),  384'(sb[0].uuid));
            chk("out_op",    384'(out_op),    384'(sb[0].op));
            chk("out_vd",    384'(out_vd),    384'(sb[0].vd));
            chk("out_vs1",   384'(out_vs_data[0]), 384'(sb[0].data[0]));
            chk("out_vs2",   384'(out_vs_data[1]), 384'(sb[0].data[1]));
            chk("out_vs3",   384'(out_vs_data[2]), 384'(sb[0].data[2]));
        end
    endtask

    task automatic drain(input int hold);
        for (int h = 0; h < hold; h++) begin
            check_out();
            tick();
        end
        out_ready = 1'b1;
        check_out();
        if (sb.size() != 0) void'(sb.pop_front());
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 384'(out_valid), 384'(1'b0));
        chk("in_ready_after_hs",  384'(in_ready),  384'(1'b1));
    endtask

    initial begin
        logic [VL-1:0] a5, ones, p11, dead, mrg;
        a5   = {16{8'hA5}};
        ones = '1;
        p11  = {16{8'h11}};
        dead = {4{32'hDEADBEEF}};

        reset = 1'b1; in_valid = 1'b0; in_wis = '0; in_uuid = '0; in_op = '0; in_vd = '0;
        in_vs = '0; in_use = '0; wb_valid = 1'b0; wb_wis = '0; wb_vd = '0; wb_be = '0;
        wb_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready",  384'(in_ready),  384'(1'b0));
        chk("rst_out_valid", 384'(out_valid), 384'(1'b0));
        chk("rst_out_data",  384'(out_vs_data), 384'(0));
        chk("rst_out_uuid",  384'(out_uuid),  384'(0));
        reset = 1'b0;
        tick();
        chk("in_ready_post_rst", 384'(in_ready), 384'(1'b1));

        // single operand, vs1=v5 warp1
        wb(2'd1, 5'd5, '1, a5);
        send(2'd1, 44'h123, 4'h3, 5'd9, 5'd5, 5'd0, 5'd0, 3'b001, a5, '0, '0, 1'b1);
        wait_valid(1, 3);
        drain(0);

        // three operands, output held 10 cycles
        wb(2'd0, 5'd1, '1, 128'd1);
        wb(2'd0, 5'd2, '1, 128'd2);
        wb(2'd0, 5'd3, '1, 128'd3);
        send(2'd0, 44'hABCDE, 4'h7, 5'd4, 5'd1, 5'd2, 5'd3, 3'b111, 128'd1, 128'd2, 128'd3, 1'b1);
        wait_valid(1, 5);
        drain(10);

        // no operands: immediate output, metadata echoed
        send(2'd3, 44'hFFF00F, 4'hC, 5'd31, 5'd7, 5'd8, 5'd9, 3'b000, '0, '0, '0, 1'b1);
        wait_valid(1, 1);
        drain(1);

        // writeback forwarded into the vs2 read, later writeback in OUT ignored
        wb(2'd2, 5'd2, '1, '0);
        send(2'd2, 44'h55, 4'h1, 5'd2, 5'd0, 5'd2, 5'd0, 3'b010, '0,
             merge('0, 16'h000F, ones), '0, 1'b1);
        wb(2'd2, 5'd2, 16'h000F, ones);
        wait_valid(2, 3);
        wb(2'd2, 5'd2, '1, ones);
        drain(2);

        // same register twice: first read forwarded, second reads updated RAM
        wb(2'd3, 5'd4, '1, p11);
        mrg = merge(p11, 16'h00F0, ones);
        send(2'd3, 44'h77, 4'h2, 5'd6, 5'd4, 5'd4, 5'd0, 3'b011, mrg, mrg, '0, 1'b1);
        wb(2'd3, 5'd4, 16'h00F0, ones);
        wait_valid(2, 4);
        drain(0);

        // v0 in non-adjacent slots
        wb(2'd0, 5'd0, '1, dead);
        send(2'd0, 44'h99, 4'h5, 5'd0, 5'd0, 5'd0, 5'd0, 3'b101, dead, '0, dead, 1'b1);
        wait_valid(1, 4);
        drain(0);

        // reset in the middle of a 3-operand fetch
        send(2'd0, 44'h42, 4'h4, 5'd1, 5'd1, 5'd2, 5'd3, 3'b111, '0, '0, '0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_in_ready",  384'(in_ready),  384'(1'b0));
        chk("midrst_out_valid", 384'(out_valid), 384'(1'b0));
        reset = 1'b0;
        tick();
        chk("in_ready_after_midrst", 384'(in_ready), 384'(1'b1));
        for (int i = 0; i < 8; i++) begin
            chk("no_out_after_rst", 384'(out_valid), 384'(1'b0));
            tick();
        end
        chk("scoreboard_empty", 384'(sb.size()), 384'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule

// File: doc/vx_vpu_operands.md
VX_VPU_OPERANDS -- requirements
Module: VX_vpu_operands

Interface
REQ-001 Parameters SHALL be:
- NUM_VREGS, 32, vector registers per warp
- VLEN, 128, bits per vector register
- PER_ISSUE_WARPS, 4, warps sharing this issue slice
REQ-002 Derived widths SHALL be VR_BITS=clog2(NUM_VREGS), WIS_W=UP(clog2(PER_ISSUE_WARPS)), BE_W=VLEN/8.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instruction valid from vector_scoreboard_if
- in_ready  out  1  accept
- in_wis  in  WIS_W  issue-slice warp index
- in_uuid  in  UUID_WIDTH  instruction uuid
- in_op  in  INST_OP_BITS  opcode, passed through
- in_vd  in  VR_BITS  destination, passed through
- in_vs  in  3*VR_BITS  source registers vs1/vs2/vs3
- in_use  in  3  per-source fetch enable
- wb_valid  in  1  vector writeback strobe
- wb_wis  in  WIS_W  writeback warp
- wb_vd  in  VR_BITS  writeback register
- wb_be  in  BE_W  byte enables
- wb_data  in  VLEN  writeback data
- out_valid  out  1  operands ready
- out_ready  in  1  consumer accept
- out_wis, out_uuid, out_op, out_vd  out  as inputs  captured metadata
- out_vs_data  out  3*VLEN  operand data, index 0 = vs1

Function
REQ-004 The block SHALL hold a vector register file of NUM_VREGS*PER_ISSUE_WARPS entries of VLEN bits, addressed {reg, wis}, with one read and one byte-enabled write port per cycle.
REQ-005 FSM states SHALL be IDLE, FETCH, DRAIN, OUT; in_ready SHALL be 1 only in IDLE.
REQ-006 On in_valid&&in_ready (cycle T) the block SHALL capture metadata, in_vs and in_use, clear all operand registers to 0, and go to FETCH if in_use!=0, else OUT.
REQ-007 In FETCH the block SHALL issue one read per cycle for each set in_use bit in ascending index order (cycles T+1..T+n, n=popcount(in_use)), then go to DRAIN.
REQ-008 Read data SHALL be captured into its operand slot the cycle after issue; DRAIN SHALL last one cycle and then go to OUT, so out_valid rises at T+n+2 (n>=1) or T+1 (n=0).
REQ-009 Unused operand slots SHALL read 0.
REQ-010 Writes SHALL apply whenever wb_valid=1, in any state, only to bytes with wb_be set.
REQ-011 A write in the same cycle as a read issue to the same address SHALL be forwarded: captured data = wb_data on enabled bytes, old RAM data elsewhere.
REQ-012 A write to an already captured operand SHALL NOT update the captured value.
REQ-013 In OUT, out_valid SHALL stay 1 and all out_* SHALL stay stable until out_ready=1; on that cycle the FSM SHALL return to IDLE, with in_ready=1 the next cycle.
REQ-014 vs registers equal in value SHALL each be fetched separately; v0 is a normal register with no special handling.

Reset
REQ-015 During reset: state=IDLE, in_ready=0, out_valid=0, operand and metadata registers=0; in_ready=1 the cycle after reset deasserts.
REQ-016 Reset mid-FETCH/DRAIN/OUT SHALL abort the instruction with no output produced; RAM contents are not reset except in debug simulation (GPR_RESET), where all entries are 0.

Structure
REQ-017 The FSM state enum and the operand count (3) SHALL live in VX_gpu_pkg.
REQ-018 Register storage SHALL be a single VX_dp_ram instance (WRENW=BE_W, OUT_REG=0, registered read capture done in this block).

Verification
REQ-019 Write v5 warp1 = 0xA5..A5 (all bytes); issue in_vs=(5,0,0), in_use=001, wis=1 -> out_valid at T+3, vs1 data=0xA5..A5, vs2=vs3=0.
REQ-020 in_use=111 with vs=(1,2,3) preloaded 1/2/3 -> out_valid at T+5, data (1,2,3); in_ready=0 from T+1 until the cycle after the out handshake.
REQ-021 in_use=000 -> out_valid at T+1, all data 0, metadata echoed.
REQ-022 wb to v2 with wb_be=0x000F, data=0xFFFF, in the cycle vs2 read issues (RAM old value 0) -> vs2 data=0x...0000FFFF; a later wb to v2 during OUT leaves output unchanged.
REQ-023 Hold out_ready=0 for 10 cycles then 1 -> out_* stable throughout, single handshake; reset asserted at T+2 of a 3-operand fetch -> out_valid never rises, in_ready=1 after reset.
